// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared state, direction and length encodings for mem_arbiter
package mem_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_LOAD    = 3'd2,
        ST_STORE   = 3'd3,
        ST_RECOVER = 3'd4
    } state_t;

    localparam logic READ_FLAG  = 1'b0;
    localparam logic WRITE_FLAG = 1'b1;

    localparam logic [2:0] LEN_BYTE = 3'd1;
    localparam logic [2:0] LEN_HALF = 3'd2;
    localparam logic [2:0] LEN_WORD = 3'd4;

endpackage

// File: rtl/mem_arbiter_load_extend.sv
// rtl/mem_arbiter_load_extend.sv - combinational sign/zero extension of raw little-endian load bytes
module mem_arbiter_load_extend #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] raw,
    input  logic [2:0]        len,
    input  logic              is_signed,
    output logic [DATA_W-1:0] data
);
    import mem_arbiter_pkg::*;

    // Unknown lengths pass the raw word through untouched.
    always_comb begin
        data = raw;
        case (len)
            LEN_BYTE: data = {{(DATA_W-8){is_signed & raw[7]}}, raw[7:0]};
            LEN_HALF: data = {{(DATA_W-16){is_signed & raw[15]}}, raw[15:0]};
            LEN_WORD: data = raw;
            default:  data = raw;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-outstanding arbiter between fetch/load/store and memory_controller
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              rollback,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_pc,
    output logic              fetch_done,
    output logic [DATA_W-1:0] fetch_inst,
    input  logic              load_req,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [2:0]        load_len,
    input  logic              load_signed,
    output logic              load_done,
    output logic [DATA_W-1:0] load_data,
    input  logic              store_req,
    input  logic [ADDR_W-1:0] store_addr,
    input  logic [2:0]        store_len,
    input  logic [DATA_W-1:0] store_data,
    output logic              store_done,
    output logic              mc_query_start,
    output logic [ADDR_W-1:0] mc_query_pc,
    input  logic              mc_query_finish,
    input  logic [DATA_W-1:0] mc_query_inst,
    output logic              mc_ls_start,
    output logic              mc_ls_wr,
    output logic [2:0]        mc_ls_len,
    output logic [ADDR_W-1:0] mc_ls_addr,
    output logic [DATA_W-1:0] mc_ls_wdata,
    input  logic              mc_ls_finish,
    input  logic [DATA_W-1:0] mc_ls_rdata,
    output logic              busy
);
    import mem_arbiter_pkg::*;

    localparam int               CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t            state;
    state_t            state_next;
    state_t            owner;
    logic [CNT_W-1:0]  starve_cnt;
    logic              discard;
    logic              got_fin;
    logic              start_pend;
    logic              done_pend;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] query_pc;
    logic [ADDR_W-1:0] ls_addr;
    logic [2:0]        ls_len;
    logic              ls_wr;
    logic              ls_signed;
    logic [DATA_W-1:0] ls_wdata;
    logic              fetch_ok;
    logic              load_ok;
    logic              in_flight;
    logic              fin_match;
    logic              fin_now;

    always_comb begin
        fetch_ok   = fetch_req && !rollback;
        load_ok    = load_req && !rollback;
        in_flight  = (state == ST_FETCH) || (state == ST_LOAD) || (state == ST_STORE);
        fin_match  = ((state == ST_FETCH) && mc_query_finish) ||
                     (((state == ST_LOAD) || (state == ST_STORE)) && mc_ls_finish);
        // got_fin remembers a finish that arrived while rdy was low
        fin_now    = fin_match || got_fin;
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (fetch_ok && (starve_cnt == CNT_MAX)) state_next = ST_FETCH;
                else if (store_req)                      state_next = ST_STORE;
                else if (load_ok)                        state_next = ST_LOAD;
                else if (fetch_ok)                       state_next = ST_FETCH;
            end
            ST_FETCH, ST_LOAD, ST_STORE: begin
                if (fin_now) state_next = ST_RECOVER;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else if (rdy) state <= state_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner      <= ST_IDLE;
            starve_cnt <= '0;
            discard    <= 1'b0;
            got_fin    <= 1'b0;
            start_pend <= 1'b0;
            done_pend  <= 1'b0;
            rdata      <= '0;
            query_pc   <= '0;
            ls_addr    <= '0;
            ls_len     <= '0;
            ls_wr      <= READ_FLAG;
            ls_signed  <= 1'b0;
            ls_wdata   <= '0;
        end else begin
            if (fin_match && !got_fin) begin
                got_fin <= 1'b1;
                rdata   <= (state == ST_FETCH) ? mc_query_inst : mc_ls_rdata;
            end
            if (rdy) begin
                start_pend <= 1'b0;
                done_pend  <= 1'b0;
                if ((state == ST_IDLE) && (state_next != ST_IDLE)) begin
                    owner      <= state_next;
                    start_pend <= 1'b1;
                    if ((state_next == ST_FETCH) || !fetch_req) starve_cnt <= '0;
                    else if (starve_cnt != CNT_MAX)             starve_cnt <= starve_cnt + CNT_ONE;
                    case (state_next)
                        ST_FETCH: query_pc <= fetch_pc;
                        ST_LOAD: begin
                            ls_addr   <= load_addr;
                            ls_len    <= load_len;
                            ls_signed <= load_signed;
                            ls_wr     <= READ_FLAG;
                        end
                        default: begin
                            ls_addr  <= store_addr;
                            ls_len   <= store_len;
                            ls_wdata <= store_data;
                            ls_wr    <= WRITE_FLAG;
                        end
                    endcase
                end
                // A rollback on the finishing edge also suppresses the fetch/load done.
                if (in_flight && fin_now) begin
                    got_fin   <= 1'b0;
                    discard   <= 1'b0;
                    done_pend <= (state == ST_STORE) || !(discard || rollback);
                end else if (rollback && ((state == ST_FETCH) || (state == ST_LOAD))) begin
                    discard <= 1'b1;
                end
            end
        end
    end

    mem_arbiter_load_extend #(.DATA_W(DATA_W)) u_load_extend (
        .raw       (rdata),
        .len       (ls_len),
        .is_signed (ls_signed),
        .data      (load_data)
    );

    assign busy           = (state != ST_IDLE);
    assign mc_query_start = rdy && start_pend && (owner == ST_FETCH);
    assign mc_ls_start    = rdy && start_pend && ((owner == ST_LOAD) || (owner == ST_STORE));
    assign fetch_done     = rdy && done_pend && (owner == ST_FETCH);
    assign load_done      = rdy && done_pend && (owner == ST_LOAD);
    assign store_done     = rdy && done_pend && (owner == ST_STORE);
    assign fetch_inst     = rdata;
    assign mc_query_pc    = query_pc;
    assign mc_ls_wr       = ls_wr;
    assign mc_ls_len      = ls_len;
    assign mc_ls_addr     = ls_addr;
    assign mc_ls_wdata    = ls_wdata;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sits between the three memory requesters and memory_controller: instruction fetch (IF/icache miss path), load (LSB) and store (commit).
- Turns level-held requests into single-cycle start pulses on memory_controller's IF and ls_ex ports, with one transaction outstanding at a time.
- Routes each finish pulse back to the owning requester and sign/zero-extends load data.
- Rollback cancels speculative fetch/load traffic without corrupting an in-flight store.

Parameters:
STARVE_LIMIT, 4, consecutive data (load/store) grants allowed while fetch_req is pending before fetch is forced next
ADDR_W, 32, address width
DATA_W, 32, data/instruction width

Ports:
clk  in  1  clock, all state on posedge
rst  in  1  asynchronous, active-low reset
rdy  in  1  global ready; low = freeze
rollback  in  1  pipeline flush pulse
fetch_req  in  1  level; held with fetch_pc until fetch_done
fetch_pc  in  32  fetch address
fetch_done  out  1  one-cycle completion pulse
fetch_inst  out  32  instruction, valid with fetch_done
load_req  in  1  level; held with operands until load_done
load_addr  in  32  load address
load_len  in  3  byte count: 1, 2 or 4
load_signed  in  1  1 = sign-extend
load_done  out  1  one-cycle pulse
load_data  out  32  extended load result
store_req  in  1  level; held until store_done
store_addr  in  32  store address
store_len  in  3  byte count: 1, 2 or 4
store_data  in  32  write data, low bytes used
store_done  out  1  one-cycle pulse
mc_query_start  out  1  pulse to memory_controller IF port
mc_query_pc  out  32  fetch address
mc_query_finish  in  1  finish pulse from memory_controller
mc_query_inst  in  32  fetched word
mc_ls_start  out  1  pulse to memory_controller ls_ex port
mc_ls_wr  out  1  0 read, 1 write
mc_ls_len  out  3  byte count
mc_ls_addr  out  32  address
mc_ls_wdata  out  32  write data
mc_ls_finish  in  1  finish pulse
mc_ls_rdata  in  32  raw little-endian bytes
busy  out  1  state != IDLE

Behaviour:
- Reset (rst low, async): state = IDLE, starve counter = 0, discard flag = 0. All outputs are 0.
- States:
  - IDLE: grant.
  - FETCH, LOAD, STORE: waiting for finish.
  - RECOVER: one dead cycle, so a requester can drop its req after its done pulse; RECOVER always returns to IDLE.
- Arbitration in IDLE at a posedge. Priority is store > load > fetch. Exception: when starve counter == STARVE_LIMIT and fetch_req = 1, fetch wins.
- On grant:
  - Next cycle, drive the matching start pulse high for exactly 1 cycle with operands registered. Operands stay stable until finish.
  - Latency from req sample to start pulse is 1 cycle.
- Starve counter:
  - Increments, saturating at STARVE_LIMIT, on each load/store grant while fetch_req = 1.
  - Clears on fetch grant or when fetch_req = 0 at grant time.
- Finish handling:
  - In FETCH or LOAD, on the matching finish, register the data and pulse fetch_done or load_done the next cycle, unless discard is set. Then go to RECOVER.
  - In STORE, mc_ls_finish gives store_done next cycle, then RECOVER.
  - Finish pulses that do not match the current state are ignored.
- Load extension:
  - len 1: bit 7 extended (signed) or zeros (unsigned) into bits 31:8.
  - len 2: bit 15 extended or zeros into bits 31:16.
  - len 4: data passes through unchanged.
  - Any other len: data passes through unmasked.
- Rollback high at a posedge:
  - FETCH or LOAD: set discard. The transaction still drains in memory_controller, but no done pulse is given. Discard clears on entry to RECOVER.
  - STORE: no effect; store_done is still given.
  - IDLE: fetch_req and load_req are ignored that cycle; a store may still be granted.
- rdy low: state, counter and discard hold. Start and done outputs are forced to 0; a pending pulse is emitted on the first cycle rdy returns high.
- A fetch_req and load_req arriving together while memory_controller is busy never happens: at most one start pulse is in flight, so memory_controller's internal buffering is never exercised.

Decomposition:
- Shared constants (state encodings, READ_FLAG/WRITE_FLAG, len encodings 1/2/4) go in constant.v.
- One sub-module, load_extend, is natural: combinational len/signed extension, also reusable by the LSB store-to-load forwarding path.

Test Plan:
- fetch_req=1, pc=0x100, mc_query_inst=0xDEADBEEF after 8 cycles -> mc_query_start pulses 1 cycle after req. fetch_done pulses with fetch_inst=0xDEADBEEF. The dead RECOVER cycle gives no second start.
- store_req, load_req and fetch_req all raised in the same cycle -> grant order store, load, fetch. Each start is preceded by RECOVER.
- Fetch held while load/store requests alternate continuously, STARVE_LIMIT=4 -> after 4 data grants the 5th grant is fetch, and the counter reads 0.
- Load at 0x20, len=1, signed=1, raw byte 0x80 -> load_data=0xFFFFFF80. With signed=0 -> 0x00000080. len=2, raw 0x8001, signed=1 -> 0xFFFF8001.
- rollback during LOAD -> mc_ls_finish arrives but load_done stays 0. With rollback during STORE -> store_done still pulses.
- Async reset mid-FETCH, then rdy held low for 3 cycles around a finish -> after reset, outputs are 0 and state is IDLE. While rdy is low, done is delayed until rdy rises and then pulses exactly once.
